// File: rtl/idann_pkg.sv
// Shared types and helpers for the hidden-neuron backward-pass engine.
package idann_pkg;

    localparam int unsigned W_W       = 8;
    localparam int unsigned N_IN      = 4;
    localparam int          GRAD_CLIP = 16;
    // Wide enough for any weight minus an (ERR_W+W_W)-bit step without overflow.
    localparam int unsigned WIDE_W    = 40;

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StUpd,
        StDone,
        StHold
    } hb_state_e;

    function automatic logic signed [W_W-1:0] saturate(input logic signed [WIDE_W-1:0] v);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = {{(WIDE_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
        lo = {{(WIDE_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}};
        if (v > hi) begin
            return hi[W_W-1:0];
        end else if (v < lo) begin
            return lo[W_W-1:0];
        end
        return v[W_W-1:0];
    endfunction

endpackage

// File: rtl/idann_sat_sub.sv
// Signed weight minus gradient step, computed wide and clamped to the weight range.
module idann_sat_sub
    import idann_pkg::*;
#(
    parameter int unsigned STEP_W = 32
) (
    input  logic signed [W_W-1:0]    w_i,
    input  logic signed [STEP_W-1:0] step_i,
    output logic signed [W_W-1:0]    w_new_o
);

    logic signed [WIDE_W-1:0] diff;

    always_comb begin
        diff    = WIDE_W'(w_i) - WIDE_W'(step_i);
        w_new_o = saturate(diff);
    end

endmodule

// File: rtl/hidden_backprop.sv
// Backward-pass weight update for one hidden neuron (four input weights).
// Optional step clamping to +/-GRAD_CLIP is enabled by defining HB_GRAD_CLIP_EN.
module hidden_backprop #(
    parameter int unsigned ERR_W    = 24,
    parameter int unsigned W_W      = 8,
    parameter int unsigned N_IN     = 4,
    parameter int unsigned LR_SHIFT = 8,
    parameter logic [31:0] W_INIT   = 32'h04030201
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   zero_weight_reset_i,
    input  logic [ERR_W-1:0]       err_i,
    input  logic [W_W-1:0]         w_out_i,
    input  logic [9:0]             hidden_val_i,
    input  logic [N_IN-1:0]        x_i,
    input  logic [N_IN*W_W-1:0]    w_i,
    output logic [N_IN*W_W-1:0]    w_o,
    output logic                   busy_o,
    output logic                   b_end_o
);

    import idann_pkg::*;

    localparam int unsigned D_W = ERR_W + W_W;

    hb_state_e               state_q;
    logic [1:0]              idx_q;
    logic [ERR_W-1:0]        err_q;
    logic [W_W-1:0]          w_out_q;
    logic [9:0]              hidden_q;
    logic [N_IN-1:0]         x_q;
    logic [N_IN*W_W-1:0]     work_q;
    logic signed [D_W-1:0]   delta_q;

    logic signed [D_W-1:0]   prod;
    logic signed [D_W-1:0]   step;
    logic signed [W_W-1:0]   w_cur;
    logic signed [W_W-1:0]   w_new;

    always_comb begin
        prod = $signed({{W_W{err_q[ERR_W-1]}}, err_q})
             * $signed({{ERR_W{w_out_q[W_W-1]}}, w_out_q});
        step = '0;
        if (x_q[idx_q]) begin
            step = delta_q >>> LR_SHIFT;
        end
`ifdef HB_GRAD_CLIP_EN
        if (step > D_W'(GRAD_CLIP)) begin
            step = D_W'(GRAD_CLIP);
        end else if (step < -D_W'(GRAD_CLIP)) begin
            step = -D_W'(GRAD_CLIP);
        end
`endif
        w_cur = work_q[idx_q*W_W +: W_W];
    end

    idann_sat_sub #(
        .STEP_W (D_W)
    ) u_sat (
        .w_i     (w_cur),
        .step_i  (step),
        .w_new_o (w_new)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            err_q    <= '0;
            w_out_q  <= '0;
            hidden_q <= '0;
            x_q      <= '0;
            work_q   <= W_INIT;
            delta_q  <= '0;
            w_o      <= W_INIT;
            busy_o   <= 1'b0;
            b_end_o  <= 1'b0;
        end else if (zero_weight_reset_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            w_o     <= w_i;
            busy_o  <= 1'b0;
            b_end_o <= 1'b0;
        end else begin
            b_end_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en_i) begin
                        err_q    <= err_i;
                        w_out_q  <= w_out_i;
                        hidden_q <= hidden_val_i;
                        x_q      <= x_i;
                        work_q   <= w_i;
                        busy_o   <= 1'b1;
                        state_q  <= StMul;
                    end
                end
                StMul: begin
                    // ReLU derivative: no gradient flows through an inactive neuron.
                    delta_q <= (hidden_q == '0) ? '0 : prod;
                    idx_q   <= '0;
                    state_q <= StUpd;
                end
                StUpd: begin
                    work_q[idx_q*W_W +: W_W] <= w_new;
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    b_end_o <= 1'b1;
                    w_o     <= work_q;
                    busy_o  <= 1'b0;
                    state_q <= StHold;
                end
                StHold: begin
                    if (!en_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hidden_backprop.sv
// Directed self-checking bench for hidden_backprop.
module tb_hidden_backprop;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        zwr;
    logic [23:0] err;
    logic [7:0]  w_out;
    logic [9:0]  hidden;
    logic [3:0]  x;
    logic [31:0] w_in;
    logic [31:0] w_o;
    logic        busy;
    logic        b_end;

    int total = 0;
    int bad   = 0;
    int first;
    int pulses;
    logic [31:0] exp_w;

    hidden_backprop dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .en_i                (en),
        .zero_weight_reset_i (zwr),
        .err_i               (err),
        .w_out_i             (w_out),
        .hidden_val_i        (hidden),
        .x_i                 (x),
        .w_i                 (w_in),
        .w_o                 (w_o),
        .busy_o              (busy),
        .b_end_o             (b_end)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks ncyc edges; reports the first edge (1-based) at which b_end was seen and pulse count.
    task automatic watch(input int ncyc, output int first_o, output int count_o);
        first_o = -1;
        count_o = 0;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            if (b_end) begin
                count_o++;
                if (first_o < 0) first_o = k;
            end
        end
    endtask

    task automatic start_run(input logic [23:0] e, input logic [7:0] wo, input logic [9:0] h,
                             input logic [3:0] xv, input logic [31:0] wv);
        err    = e;
        w_out  = wo;
        hidden = h;
        x      = xv;
        w_in   = wv;
        en     = 1'b1;
        tick();
        en     = 1'b0;
        // Inputs changing after capture must not matter.
        err    = 24'h7FFFFF;
        w_out  = 8'h80;
        x      = 4'b0000;
        w_in   = 32'hDEADBEEF;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; zwr = 1'b0;
        err = '0; w_out = '0; hidden = '0; x = '0; w_in = '0;
        tick(); tick();
        rst = 1'b0;
        check_eq("reset_w", w_o, 32'h04030201);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_bend", {31'd0, b_end}, 32'd0);

        // Basic update: delta=512, step=2 on x[0], x[2].
        start_run(24'd256, 8'd2, 10'd5, 4'b0101, 32'h04030201);
        check_eq("basic_busy", {31'd0, busy}, 32'd1);
        watch(12, first, pulses);
        check_eq("basic_pulse_at", first, 32'd6);
        check_eq("basic_pulses", pulses, 32'd1);
        check_eq("basic_w", w_o, 32'h040102FF);
        check_eq("basic_busy_end", {31'd0, busy}, 32'd0);

        // ReLU gate: inactive neuron leaves weights as captured.
        start_run(24'd256, 8'd2, 10'd0, 4'b0101, 32'h04030201);
        watch(12, first, pulses);
        check_eq("relu_pulse_at", first, 32'd6);
        check_eq("relu_w", w_o, 32'h04030201);

        // Large negative gradient: weights pushed up to the positive rail.
`ifdef HB_GRAD_CLIP_EN
        exp_w = 32'h74747474;
`else
        exp_w = 32'h7F7F7F7F;
`endif
        start_run(24'hF00000, 8'd127, 10'd5, 4'b1111, 32'h64646464);
        watch(12, first, pulses);
        check_eq("sat_pos_w", w_o, exp_w);

        // Large positive gradient from -100 weights: negative rail.
`ifdef HB_GRAD_CLIP_EN
        exp_w = 32'h8C8C8C8C;
`else
        exp_w = 32'h80808080;
`endif
        start_run(24'h100000, 8'd127, 10'd5, 4'b1111, 32'h9C9C9C9C);
        watch(12, first, pulses);
        check_eq("sat_neg_w", w_o, exp_w);

        // Reset sampled at N+3 aborts the run.
        start_run(24'd256, 8'd2, 10'd5, 4'b1111, 32'h10101010);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_w", w_o, 32'h04030201);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        watch(10, first, pulses);
        check_eq("rst_mid_pulses", pulses, 32'd0);

        // en held high: exactly one run.
        err = 24'd256; w_out = 8'd2; hidden = 10'd5; x = 4'b0101; w_in = 32'h04030201;
        en = 1'b1;
        tick();
        watch(19, first, pulses);
        check_eq("hold_pulse_at", first, 32'd6);
        check_eq("hold_pulses", pulses, 32'd1);
        en = 1'b0;
        tick();
        start_run(24'd256, 8'd2, 10'd5, 4'b1111, 32'h0A0A0A0A);
        watch(12, first, pulses);
        check_eq("rerun_pulse_at", first, 32'd6);
        check_eq("rerun_w", w_o, 32'h08080808);

        // zero_weight_reset during UPD reloads weights and aborts.
        start_run(24'd256, 8'd2, 10'd5, 4'b1111, 32'h20202020);
        tick();
        tick();
        zwr  = 1'b1;
        w_in = 32'h11223344;
        tick();
        zwr  = 1'b0;
        check_eq("zwr_w", w_o, 32'h11223344);
        check_eq("zwr_busy", {31'd0, busy}, 32'd0);
        watch(10, first, pulses);
        check_eq("zwr_pulses", pulses, 32'd0);
        check_eq("zwr_w_kept", w_o, 32'h11223344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
